// File: rtl/mux_arb_if.sv
// mux_arb_if: handshake bundle between two requesters, the arbiter and the downstream sink
interface mux_arb_if #(parameter int DATA_W = 8);
    logic              a_valid_i;
    logic [DATA_W-1:0] a_data_i;
    logic              a_ready_o;
    logic              b_valid_i;
    logic [DATA_W-1:0] b_data_i;
    logic              b_ready_o;
    logic              y_valid_o;
    logic [DATA_W-1:0] y_o;
    logic              y_ready_i;
    logic              sel_o;
    modport slave (
        input  a_valid_i, a_data_i, b_valid_i, b_data_i, y_ready_i,
        output a_ready_o, b_ready_o, y_valid_o, y_o, sel_o
    );
    modport master (
        output a_valid_i, a_data_i, b_valid_i, b_data_i, y_ready_i,
        input  a_ready_o, b_ready_o, y_valid_o, y_o, sel_o
    );
endinterface

// File: rtl/mux_arb.sv
// mux_arb: round-robin 2:1 arbiter feeding a one-word registered output slot
module mux_arb #(
    parameter int DATA_W = 8
) (
    input logic      clk,
    input logic      reset_n,
    mux_arb_if.slave bus
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t            state;
    logic              last_grant;
    logic              free;
    logic              grant_a;
    logic              grant_b;
    logic [DATA_W-1:0] next_y;
    // last_grant: 0 = A, 1 = B; the requester not granted last wins a conflict
    always_comb begin
        free    = (state == IDLE) || bus.y_ready_i;
        grant_a = reset_n && free && bus.a_valid_i && (!bus.b_valid_i || last_grant);
        grant_b = reset_n && free && bus.b_valid_i && (!bus.a_valid_i || !last_grant);
        next_y  = grant_b ? bus.b_data_i : bus.a_data_i;
    end
    assign bus.a_ready_o = grant_a;
    assign bus.b_ready_o = grant_b;
    assign bus.y_valid_o = (state == HOLD);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            bus.y_o    <= '0;
            bus.sel_o  <= 1'b0;
            last_grant <= 1'b1;
        end else if (grant_a || grant_b) begin
            state      <= HOLD;
            bus.y_o    <= next_y;
            bus.sel_o  <= grant_b;
            last_grant <= grant_b;
        end else if (free) begin
            state      <= IDLE;
        end
    end
endmodule

// File: tb/tb_mux_arb.sv
// tb_mux_arb: vector table plus hand sequences, checked against an arbiter model and a word scoreboard
module tb_mux_arb;
    logic clk;
    logic reset_n;
    mux_arb_if #(.DATA_W(8)) bus();
    mux_arb #(.DATA_W(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       av;
        logic [7:0] ad;
        logic       bv;
        logic [7:0] bd;
        logic       yr;
        logic       ea;
        logic       eb;
    } vec_t;

    vec_t       v[12];
    int         total = 0;
    int         bad = 0;
    logic       m_hold;
    logic       m_last;
    logic [8:0] m_out;
    logic [8:0] q[$];

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic av, input logic [7:0] ad, input logic bv,
                         input logic [7:0] bd, input logic yr);
        bus.a_valid_i = av;
        bus.a_data_i  = ad;
        bus.b_valid_i = bv;
        bus.b_data_i  = bd;
        bus.y_ready_i = yr;
    endtask

    // checks the cycle at the falling edge, then advances the model across the rising edge
    task automatic step();
        logic free, ea, eb;
        @(negedge clk);
        if (!reset_n) begin
            m_hold = 1'b0;
            m_last = 1'b1;
            m_out  = '0;
            q.delete();
        end
        free = !m_hold || bus.y_ready_i;
        ea = reset_n && free && bus.a_valid_i && (!bus.b_valid_i || m_last);
        eb = reset_n && free && bus.b_valid_i && (!bus.a_valid_i || !m_last);
        cmp("y_valid", 16'(bus.y_valid_o), 16'(m_hold));
        cmp("a_ready", 16'(bus.a_ready_o), 16'(ea));
        cmp("b_ready", 16'(bus.b_ready_o), 16'(eb));
        if (m_hold && q.size() > 0) begin
            cmp("held_word", 16'({bus.sel_o, bus.y_o}), 16'(q[0]));
            if (bus.y_ready_i) m_out = q.pop_front();
        end else if (!m_hold) begin
            cmp("idle_word", 16'({bus.sel_o, bus.y_o}), 16'(m_out));
        end
        if (ea) q.push_back({1'b0, bus.a_data_i});
        if (eb) q.push_back({1'b1, bus.b_data_i});
        if (ea || eb) m_last = eb;
        m_hold = ea || eb || (m_hold && !bus.y_ready_i);
        @(posedge clk);
        #1;
    endtask

    initial begin
        v[0]  = '{1'b1, 8'h00, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0};
        v[1]  = '{1'b1, 8'h00, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1};
        v[2]  = '{1'b1, 8'h00, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0};
        v[3]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        v[4]  = '{1'b1, 8'h12, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        v[5]  = '{1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0};
        v[6]  = '{1'b0, 8'h00, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1};
        v[7]  = '{1'b1, 8'h33, 1'b1, 8'h44, 1'b1, 1'b1, 1'b0};
        v[8]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        v[9]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        v[10] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        v[11] = '{1'b1, 8'h66, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1};
        m_hold = 1'b0;
        m_last = 1'b1;
        m_out  = '0;
        reset_n = 1'b0;
        drive(1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1);
        @(posedge clk);
        #1;
        cmp("rst_y_valid", 16'(bus.y_valid_o), 16'h0);
        cmp("rst_y", 16'(bus.y_o), 16'h0);
        cmp("rst_sel", 16'(bus.sel_o), 16'h0);
        cmp("rst_a_ready", 16'(bus.a_ready_o), 16'h0);
        cmp("rst_b_ready", 16'(bus.b_ready_o), 16'h0);
        step();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(v[i].av, v[i].ad, v[i].bv, v[i].bd, v[i].yr);
            #1;
            cmp($sformatf("vec%0d_a_ready", i), 16'(bus.a_ready_o), 16'(v[i].ea));
            cmp($sformatf("vec%0d_b_ready", i), 16'(bus.b_ready_o), 16'(v[i].eb));
            step();
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step();
        step();
        // backpressure: 8'h56 must sit in the slot while B waits
        drive(1'b1, 8'h56, 1'b0, 8'h00, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b1, 8'h78, 1'b0);
        for (int i = 0; i < 5; i++) step();
        cmp("bp_y", 16'(bus.y_o), 16'h56);
        cmp("bp_b_ready", 16'(bus.b_ready_o), 16'h0);
        bus.y_ready_i = 1'b1;
        step();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        cmp("bp_next_y", 16'({bus.sel_o, bus.y_o}), 16'h178);
        step();
        step();
        // streaming: one word per cycle, alternating sources
        drive(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            bus.a_data_i = 8'hA0 + 8'(i);
            bus.b_data_i = 8'hB0 + 8'(i);
            step();
            cmp($sformatf("stream%0d_valid", i), 16'(bus.y_valid_o), 16'h1);
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step();
        step();
        // reset mid-HOLD clears the slot without a clock edge
        drive(1'b1, 8'h34, 1'b0, 8'h00, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        cmp("pre_rst_y", 16'(bus.y_o), 16'h34);
        reset_n = 1'b0;
        #1;
        cmp("async_rst_valid", 16'(bus.y_valid_o), 16'h0);
        cmp("async_rst_y", 16'(bus.y_o), 16'h0);
        cmp("async_rst_sel", 16'(bus.sel_o), 16'h0);
        step();
        reset_n = 1'b1;
        drive(1'b0, 8'h00, 1'b1, 8'h9A, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step();
        step();
        cmp("drain_y", 16'({bus.sel_o, bus.y_o}), 16'h19A);
        cmp("sb_left", 16'(q.size()), 16'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
